// File: rtl/bouncing_box_renderer_pkg.sv
// Shared definitions for the bouncing box renderer: raster defaults,
// FSM state encodings and the 8-entry bounce palette.
package bouncing_box_renderer_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_UPD_X = 2'd1,
        S_UPD_Y = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Palette colours are {B,G,R}; index advances on every bounce
    function automatic logic [11:0] paletteColor(input logic [2:0] idx);
        logic [11:0] color;
        case (idx)
            3'd0:    color = 12'h00F;
            3'd1:    color = 12'h0F0;
            3'd2:    color = 12'hF00;
            3'd3:    color = 12'h0FF;
            3'd4:    color = 12'hF0F;
            3'd5:    color = 12'hFF0;
            3'd6:    color = 12'hFFF;
            default: color = 12'h888;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/bouncing_box_renderer_debouncer.sv
// Push-button conditioner: synchronises the raw button, accepts a new level
// only after it has been stable for DB_CYCLES clocks, and emits a one-clock
// pulse on each accepted 0->1 transition.
module bouncing_box_renderer_debouncer #(
    parameter int DB_CYCLES = 2000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_count;

    // Synchronise, then count consecutive cycles the input disagrees with the accepted level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_count  <= '0;
            o_pulse  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            o_pulse <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_count <= '0;
            end else if (r_count == CW'(DB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_count  <= '0;
                o_pulse  <= r_sync2;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bouncing_box_renderer.sv
// Pixel source for the VGA interface: draws a square that moves once per
// frame during vertical blank, bounces off the screen edges, changes colour
// on every bounce, and can be paused with a debounced push-button.
module bouncing_box_renderer
    import bouncing_box_renderer_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_DEF,
    parameter int          V_ACTIVE  = V_ACTIVE_DEF,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP_X    = 2,
    parameter int          STEP_Y    = 1,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter int          DB_CYCLES = 2000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [9:0]  i_xCoord,
    input  logic [9:0]  i_yCoord,
    input  logic        i_btnPause,
    output logic [11:0] o_pixelColor,
    output logic [7:0]  o_bounceCount,
    output logic        o_paused
);

    localparam logic [10:0] XMAX    = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] YMAX    = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] X_START = 11'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [10:0] Y_START = 11'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [10:0] SX      = 11'(STEP_X);
    localparam logic [10:0] SY      = 11'(STEP_Y);
    localparam logic [10:0] HA      = 11'(H_ACTIVE);
    localparam logic [10:0] VA      = 11'(V_ACTIVE);
    localparam logic [10:0] BS      = 11'(BOX_SIZE);

    state_t      r_state;
    logic [9:0]  r_prevY;
    logic [10:0] r_boxX;
    logic [10:0] r_boxY;
    logic        r_dirX;
    logic        r_dirY;
    logic        r_hitX;
    logic [2:0]  r_palIdx;
    logic [7:0]  r_bounceCount;
    logic        r_pausePending;
    logic        r_paused;

    logic        w_btnPulse;
    logic        w_frameTick;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_inside;
    logic [10:0] w_nextX;
    logic        w_nextDirX;
    logic        w_hitX;
    logic [10:0] w_nextY;
    logic        w_nextDirY;
    logic        w_hitY;

    bouncing_box_renderer_debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debouncer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btnPause),
        .o_pulse (w_btnPulse)
    );

    assign w_x         = {1'b0, i_xCoord};
    assign w_y         = {1'b0, i_yCoord};
    assign w_frameTick = (w_y == VA) && ({1'b0, r_prevY} != VA);

    // Candidate horizontal move: clamp to the edge and reverse when the step would reach it
    always_comb begin
        w_nextX    = r_boxX;
        w_nextDirX = r_dirX;
        w_hitX     = 1'b0;
        if (r_dirX) begin
            if (r_boxX + SX >= XMAX) begin
                w_nextX    = XMAX;
                w_nextDirX = 1'b0;
                w_hitX     = 1'b1;
            end else begin
                w_nextX = r_boxX + SX;
            end
        end else begin
            if (r_boxX <= SX) begin
                w_nextX    = '0;
                w_nextDirX = 1'b1;
                w_hitX     = 1'b1;
            end else begin
                w_nextX = r_boxX - SX;
            end
        end
    end

    // Candidate vertical move, mirroring the horizontal rule
    always_comb begin
        w_nextY    = r_boxY;
        w_nextDirY = r_dirY;
        w_hitY     = 1'b0;
        if (r_dirY) begin
            if (r_boxY + SY >= YMAX) begin
                w_nextY    = YMAX;
                w_nextDirY = 1'b0;
                w_hitY     = 1'b1;
            end else begin
                w_nextY = r_boxY + SY;
            end
        end else begin
            if (r_boxY <= SY) begin
                w_nextY    = '0;
                w_nextDirY = 1'b1;
                w_hitY     = 1'b1;
            end else begin
                w_nextY = r_boxY - SY;
            end
        end
    end

    // Frame-update FSM: one X step, one Y step, then hold until vertical blank line ends
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_WAIT;
            r_prevY        <= '0;
            r_boxX         <= X_START;
            r_boxY         <= Y_START;
            r_dirX         <= 1'b1;
            r_dirY         <= 1'b1;
            r_hitX         <= 1'b0;
            r_palIdx       <= '0;
            r_bounceCount  <= '0;
            r_pausePending <= 1'b0;
            r_paused       <= 1'b0;
        end else begin
            r_prevY <= i_yCoord;
            if (w_btnPulse) begin
                r_pausePending <= ~r_pausePending;
            end
            if (w_frameTick) begin
                r_paused <= r_pausePending;
            end
            case (r_state)
                S_WAIT: begin
                    if (w_frameTick) begin
                        r_state <= r_pausePending ? S_HOLD : S_UPD_X;
                    end
                end
                S_UPD_X: begin
                    r_boxX  <= w_nextX;
                    r_dirX  <= w_nextDirX;
                    r_hitX  <= w_hitX;
                    r_state <= S_UPD_Y;
                end
                S_UPD_Y: begin
                    r_boxY <= w_nextY;
                    r_dirY <= w_nextDirY;
                    if (r_hitX || w_hitY) begin
                        r_bounceCount <= r_bounceCount + 8'd1;
                        r_palIdx      <= r_palIdx + 3'd1;
                    end
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_y != VA) begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign w_inside = (w_x >= r_boxX) && (w_x < r_boxX + BS) &&
                      (w_y >= r_boxY) && (w_y < r_boxY + BS) &&
                      (w_x < HA) && (w_y < VA);

    // Registered pixel colour, one clock behind the incoming coordinates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pixelColor <= BG_COLOR;
        end else begin
            o_pixelColor <= w_inside ? paletteColor(r_palIdx) : BG_COLOR;
        end
    end

    assign o_bounceCount = r_bounceCount;
    assign o_paused      = r_paused;

endmodule
